// File: rtl/apb_master_arbiter_if.sv
// Bundles the requester-side handshake and the APB pins of apb_master_arbiter.
// master = arbiter view, slave = requesters plus APB slave view.
interface apb_master_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_ack;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_rdata;
    logic                      rsp_err;
    logic                      PWRITE;
    logic [ADDR_W-1:0]         PADDAR;
    logic                      PSLEx;
    logic [DATA_W-1:0]         PWDATA;
    logic                      PENABLE;
    logic [DATA_W-1:0]         PRDATA;
    logic                      PREADY;
    logic                      PSLVERR;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY, PSLVERR,
        output req_ack, rsp_valid, rsp_rdata, rsp_err,
        output PWRITE, PADDAR, PSLEx, PWDATA, PENABLE
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY, PSLVERR,
        input  req_ack, rsp_valid, rsp_rdata, rsp_err,
        input  PWRITE, PADDAR, PSLEx, PWDATA, PENABLE
    );
endinterface

// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter + APB master sequencer sharing one APB slave among NUM_REQ requesters.
// Optional ACCESS-phase timeout abort enabled by defining APB_TIMEOUT_EN.
module apb_master_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              PCLK,
    input  logic              RESET,
    apb_master_arbiter_if.master bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic               pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]  paddr_q, paddr_d;
    logic [DATA_W-1:0]  pwdata_q, pwdata_d;
    logic               psel_q, psel_d;
    logic               penable_q, penable_d;
    logic [NUM_REQ-1:0] req_ack_q, req_ack_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic               rsp_err_q, rsp_err_d;

    logic [ADDR_W-1:0]  addr_a  [NUM_REQ];
    logic [DATA_W-1:0]  wdata_a [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign addr_a[i]  = bus.req_addr[i*ADDR_W +: ADDR_W];
        assign wdata_a[i] = bus.req_wdata[i*DATA_W +: DATA_W];
    end

    // Round-robin: scan downward so the nearest requester after grant_q wins.
    logic             any_req;
    logic [IDX_W-1:0] win;
    logic [IDX_W-1:0] cand;
    always_comb begin
        any_req = |bus.req_valid;
        win     = grant_q;
        cand    = grant_q;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = IDX_W'((int'(grant_q) + k) % NUM_REQ);
            if (bus.req_valid[cand]) win = cand;
        end
    end

    logic timeout;
    logic done;

`ifdef APB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;

    // Fires on the ACCESS cycle that would bring the count to TIMEOUT_CYCLES,
    // so a stuck slave sees exactly TIMEOUT_CYCLES ACCESS cycles.
    assign timeout = (state_q == S_ACCESS) && !bus.PREADY &&
                     (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        tmo_d = tmo_q;
        if (state_q == S_SETUP)
            tmo_d = '0;
        else if (state_q == S_ACCESS && !bus.PREADY)
            tmo_d = tmo_q + 1'b1;
    end

    always_ff @(posedge PCLK or posedge RESET) begin
        if (RESET) tmo_q <= '0;
        else       tmo_q <= tmo_d;
    end
`else
    assign timeout = 1'b0;
`endif

    assign done = bus.PREADY || timeout;

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        req_ack_d   = '0;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            S_IDLE: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
            S_SETUP: begin
                state_d   = S_ACCESS;
                penable_d = 1'b1;
            end
            S_ACCESS: begin
                if (done) begin
                    rsp_valid_d[grant_q] = 1'b1;
                    rsp_rdata_d = (pwrite_q || timeout) ? '0 : bus.PRDATA;
                    rsp_err_d   = timeout ? 1'b1 : bus.PSLVERR;
                    state_d     = S_IDLE;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                end
            end
            default: begin
                state_d   = S_IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase

        // New grant from IDLE, or back-to-back straight out of a completing ACCESS.
        if (any_req && (state_q == S_IDLE || (state_q == S_ACCESS && done))) begin
            state_d        = S_SETUP;
            grant_d        = win;
            pwrite_d       = bus.req_write[win];
            paddr_d        = addr_a[win];
            pwdata_d       = wdata_a[win];
            psel_d         = 1'b1;
            penable_d      = 1'b0;
            req_ack_d[win] = 1'b1;
        end
    end

    always_ff @(posedge PCLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            grant_q     <= IDX_W'(NUM_REQ - 1);
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            req_ack_q   <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            req_ack_q   <= req_ack_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.req_ack   = req_ack_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.PWRITE    = pwrite_q;
    assign bus.PADDAR    = paddr_q;
    assign bus.PSLEx     = psel_q;
    assign bus.PWDATA    = pwdata_q;
    assign bus.PENABLE   = penable_q;
endmodule

// File: tb/tb_apb_master_arbiter.sv
// Scoreboard bench for apb_master_arbiter: directed requests, an address-decoded APB slave,
// and a monitor that checks grants and responses against queued expectations.
module tb_apb_master_arbiter;
    localparam int NR = 2;
    localparam int AW = 8;
    localparam int DW = 32;

    logic PCLK = 1'b0;
    logic RESET = 1'b1;
    always #5 PCLK = ~PCLK;

    apb_master_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

    apb_master_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(16)) dut (
        .PCLK  (PCLK),
        .RESET (RESET),
        .bus   (bus)
    );

    typedef struct { int idx; logic [DW-1:0] rdata; logic err; } rsp_t;
    typedef struct { int idx; logic [AW-1:0] addr; } gnt_t;

    rsp_t rsp_q[$];
    gnt_t gnt_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   stuck = 1'b0;
    int   acc_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic exp_gnt(input int idx, input logic [AW-1:0] a);
        gnt_t g;
        g.idx = idx; g.addr = a;
        gnt_q.push_back(g);
    endtask

    task automatic exp_rsp(input int idx, input logic [DW-1:0] d, input logic e);
        rsp_t r;
        r.idx = idx; r.rdata = d; r.err = e;
        rsp_q.push_back(r);
    endtask

    function automatic int oh_idx(input logic [NR-1:0] v);
        int r = -1;
        int n = 0;
        for (int i = 0; i < NR; i++) if (v[i]) begin r = i; n++; end
        return (n == 1) ? r : -1;
    endfunction

    // APB slave: addr 0x20 inserts 2 wait states, 0xFF errors, reads return a fixed pattern.
    always @(negedge PCLK) begin
        if (bus.PSLEx && bus.PENABLE) acc_cnt++;
        else                          acc_cnt = 0;
        bus.PREADY  = bus.PSLEx && bus.PENABLE && !stuck &&
                      (acc_cnt > ((bus.PADDAR == 8'h20) ? 2 : 0));
        bus.PRDATA  = (bus.PADDAR == 8'h20) ? 32'h12345678 : {24'h5A5A5A, bus.PADDAR};
        bus.PSLVERR = bus.PREADY && (bus.PADDAR == 8'hFF);
    end

    // Monitor: pops expectations whenever the DUT acks or responds.
    always @(negedge PCLK) begin
        gnt_t g;
        rsp_t r;
        if (!RESET) begin
            if (bus.req_ack != '0) begin
                if (gnt_q.size() == 0) check("unexpected_ack", 64'(bus.req_ack), 64'd0);
                else begin
                    g = gnt_q.pop_front();
                    check("grant_idx", 64'(oh_idx(bus.req_ack)), 64'(g.idx));
                    check("setup_addr", 64'(bus.PADDAR), 64'(g.addr));
                    check("setup_phase", 64'({bus.PSLEx, bus.PENABLE}), 64'(2'b10));
                end
            end
            if (bus.rsp_valid != '0) begin
                if (rsp_q.size() == 0) check("unexpected_rsp", 64'(bus.rsp_valid), 64'd0);
                else begin
                    r = rsp_q.pop_front();
                    check("rsp_idx", 64'(oh_idx(bus.rsp_valid)), 64'(r.idx));
                    check("rsp_rdata", 64'(bus.rsp_rdata), 64'(r.rdata));
                    check("rsp_err", 64'(bus.rsp_err), 64'(r.err));
                end
            end
        end
    end

    task automatic tick();
        @(negedge PCLK);
    endtask

    task automatic drive(input int idx, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req_write[idx]          = wr;
        bus.req_addr[idx*AW +: AW]  = a;
        bus.req_wdata[idx*DW +: DW] = d;
        bus.req_valid[idx]          = 1'b1;
    endtask

    // Single request; returns the number of PENABLE-high cycles before rsp_valid.
    task automatic xfer(input int idx, input bit wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, output int en);
        int t;
        exp_gnt(idx, a);
        drive(idx, wr, a, d);
        t = 0;
        do begin tick(); t++; end while (!bus.req_ack[idx] && t < 20);
        check("ack_seen", 64'(bus.req_ack[idx]), 64'd1);
        bus.req_valid[idx] = 1'b0;
        en = 0; t = 0;
        do begin tick(); t++; if (bus.PENABLE) en++; end while (!bus.rsp_valid[idx] && t < 60);
        check("rsp_seen", 64'(bus.rsp_valid[idx]), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        int en, t, acks, gap;
        bus.req_valid = '0;
        bus.req_write = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        RESET = 1'b1;
        repeat (2) tick();
        check("reset_ctl", 64'({bus.req_ack, bus.rsp_valid, bus.rsp_err, bus.PSLEx, bus.PENABLE, bus.PWRITE}), 64'd0);
        check("reset_data", 64'({bus.rsp_rdata, bus.PWDATA}), 64'd0);
        check("reset_addr", 64'(bus.PADDAR), 64'd0);
        RESET = 1'b0;
        tick();

        // Single write: exact cycle-by-cycle latency.
        exp_gnt(0, 8'h10);
        exp_rsp(0, 32'h0, 1'b0);
        drive(0, 1'b1, 8'h10, 32'hDEADBEEF);
        tick();
        check("t1_setup_phase", 64'({bus.PSLEx, bus.PENABLE, bus.PWRITE}), 64'(3'b101));
        check("t1_setup_wdata", 64'(bus.PWDATA), 64'hDEADBEEF);
        check("t1_setup_ack", 64'(bus.req_ack), 64'(2'b01));
        bus.req_valid[0] = 1'b0;
        tick();
        check("t1_access_phase", 64'({bus.PSLEx, bus.PENABLE}), 64'(2'b11));
        tick();
        check("t1_rsp_cycle3", 64'(bus.rsp_valid), 64'(2'b01));
        check("t1_idle_phase", 64'({bus.PSLEx, bus.PENABLE}), 64'd0);
        tick();
        check("t1_idle_hold_wdata", 64'(bus.PWDATA), 64'hDEADBEEF);

        // Read with 2 wait states.
        exp_rsp(1, 32'h12345678, 1'b0);
        xfer(1, 1'b0, 8'h20, 32'h0, en);
        check("t2_penable_cycles", 64'(en), 64'd3);

        // Both requesters continuously valid: 0,1,0,1 back-to-back.
        exp_gnt(0, 8'h30); exp_gnt(1, 8'h40); exp_gnt(0, 8'h30); exp_gnt(1, 8'h40);
        exp_rsp(0, 32'h0, 1'b0); exp_rsp(1, 32'h0, 1'b0);
        exp_rsp(0, 32'h0, 1'b0); exp_rsp(1, 32'h0, 1'b0);
        drive(0, 1'b1, 8'h30, 32'h11111111);
        drive(1, 1'b1, 8'h40, 32'h22222222);
        acks = 0; gap = 0; t = 0;
        while (acks < 4 && t < 40) begin
            tick(); t++;
            if (bus.req_ack != '0) acks++;
            else if (acks > 0 && !bus.PSLEx) gap++;
        end
        bus.req_valid = '0;
        check("t3_acks", 64'(acks), 64'd4);
        check("t3_idle_gaps", 64'(gap), 64'd0);
        repeat (3) tick();

        // Slave error, then a clean write and a plain read.
        exp_rsp(0, 32'h0, 1'b1);
        xfer(0, 1'b1, 8'hFF, 32'hCAFEF00D, en);
        exp_rsp(1, 32'h0, 1'b0);
        xfer(1, 1'b1, 8'h11, 32'h0BADF00D, en);
        exp_rsp(0, 32'h5A5A5A22, 1'b0);
        xfer(0, 1'b0, 8'h22, 32'h0, en);
        check("t4_no_wait_penable", 64'(en), 64'd1);

        // Reset mid-ACCESS, both requesters pending across reset.
        exp_gnt(0, 8'h20);
        drive(0, 1'b0, 8'h20, 32'h0);
        t = 0;
        do begin tick(); t++; end while (!bus.req_ack[0] && t < 20);
        tick();
        check("t5_in_access", 64'({bus.PSLEx, bus.PENABLE}), 64'(2'b11));
        drive(0, 1'b1, 8'h50, 32'h55555555);
        drive(1, 1'b1, 8'h60, 32'h66666666);
        RESET = 1'b1;
        #1;
        check("t5_async_drop", 64'({bus.PSLEx, bus.PENABLE}), 64'd0);
        tick();
        check("t5_no_rsp_in_reset", 64'(bus.rsp_valid), 64'd0);
        tick();
        RESET = 1'b0;
        exp_gnt(0, 8'h50); exp_gnt(1, 8'h60);
        exp_rsp(0, 32'h0, 1'b0); exp_rsp(1, 32'h0, 1'b0);
        acks = 0; t = 0;
        while (acks < 2 && t < 30) begin
            tick(); t++;
            if (bus.req_ack[0]) begin bus.req_valid[0] = 1'b0; acks++; end
            if (bus.req_ack[1]) begin bus.req_valid[1] = 1'b0; acks++; end
        end
        check("t5_acks_after_reset", 64'(acks), 64'd2);

`ifdef APB_TIMEOUT_EN
        repeat (4) tick();
        stuck = 1'b1;
        exp_rsp(0, 32'h0, 1'b1);
        xfer(0, 1'b0, 8'h33, 32'h0, en);
        check("t6_timeout_cycles", 64'(en), 64'd16);
        check("t6_back_to_idle", 64'(bus.PSLEx), 64'd0);
        stuck = 1'b0;
`endif

        t = 0;
        while ((rsp_q.size() != 0 || gnt_q.size() != 0) && t < 50) begin tick(); t++; end
        repeat (2) tick();
        check("rsp_queue_drained", 64'(rsp_q.size()), 64'd0);
        check("gnt_queue_drained", 64'(gnt_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
